// File: rtl/register_file_reader.sv
// Streams a range of register-file words over a valid/ready port with index and last flag.
// Optional build macro REG_READER_SKIP_ZERO_EN suppresses the hardwired-zero register 0.
module register_file_reader #(
  parameter int WORD_LENGTH = 32,
  parameter int NBITS       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NBITS-1:0]       first_reg,
  input  logic [NBITS-1:0]       last_reg,
  input  logic                   abort,
  output logic [NBITS-1:0]       rf_addr,
  input  logic [WORD_LENGTH-1:0] rf_data,
  output logic [WORD_LENGTH-1:0] out_data,
  output logic [NBITS-1:0]       out_index,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NBITS-1:0] CNT_ONE = NBITS'(1);

  state_t           state;
  state_t           state_next;
  logic [NBITS-1:0] cnt;
  logic [NBITS-1:0] end_reg;
  logic             handshake;
  logic             is_last;
  logic             skip_zero;
  logic             do_load;
  logic             do_capture;
  logic             cnt_inc;
  logic             clear_valid;

  assign handshake = out_valid && out_ready;
  assign rf_addr   = cnt;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef REG_READER_SKIP_ZERO_EN
  // A range ending at 0 never visits 0, so the word just before the wrap is the last one.
  assign skip_zero = (cnt == '0);
  assign is_last   = (cnt == end_reg) || ((end_reg == '0) && (cnt == '1));
`else
  assign skip_zero = 1'b0;
  assign is_last   = (cnt == end_reg);
`endif

  // NOTE: every signal written in this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_capture  = 1'b0;
    cnt_inc     = 1'b0;
    clear_valid = 1'b0;
    if (abort && (state != IDLE)) begin
      state_next  = IDLE;
      clear_valid = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            do_load    = 1'b1;
            state_next = FETCH;
          end
        end
        FETCH: begin
          if (skip_zero) begin
            if (cnt == end_reg) begin
              state_next = DONE;
            end else begin
              cnt_inc = 1'b1;
            end
          end else begin
            do_capture = 1'b1;
            state_next = SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            clear_valid = 1'b1;
            if (out_last) begin
              state_next = DONE;
            end else begin
              cnt_inc    = 1'b1;
              state_next = FETCH;
            end
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      end_reg   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (do_load) begin
        cnt     <= first_reg;
        end_reg <= last_reg;
      end else if (cnt_inc) begin
        cnt <= cnt + CNT_ONE;
      end
      // rf_data is the combinational read before the edge, so a same-cycle write is not seen.
      if (do_capture) begin
        out_data  <= rf_data;
        out_index <= cnt;
        out_last  <= is_last;
        out_valid <= 1'b1;
      end else if (clear_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
